// File: rtl/matriz_vga_renderer.sv
// rtl/matriz_vga_renderer.sv - VGA renderer drawing a 10x10 matrix of 4-bit cells as a palette-coloured grid
//
// Purpose: generates VGA timing (640x480@60 with default parameters) and draws
// the matrix as a centred grid of CELL x CELL cells with 1-pixel grid lines.
// The matrix is snapshotted once per frame at (hc=0, vc=V_VIS) so a frame never tears.
//
// Ports:
//   clk          pixel clock
//   rst          asynchronous active-low reset
//   matriz       cell values, matriz[row][col], 4 bits each
//   hsync/vsync  active-low syncs
//   blank_n      high in the visible area
//   r, g, b      8-bit colour channels
//   frame_start  one-cycle pulse aligned with output pixel (0,0)
//
// All outputs for counter position (hc,vc) appear 2 clocks after the counters hold it.

module matriz_vga_renderer #(
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int GRID_X0 = 120,
    parameter int GRID_Y0 = 40,
    parameter int CELL    = 40
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [9:0][9:0][3:0]  matriz,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  blank_n,
    output logic [7:0]            r,
    output logic [7:0]            g,
    output logic [7:0]            b,
    output logic                  frame_start
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] HC_LAST  = 10'(H_TOT - 1);
    localparam logic [9:0] VC_LAST  = 10'(V_TOT - 1);
    localparam logic [9:0] HC_VIS   = 10'(H_VIS);
    localparam logic [9:0] VC_VIS   = 10'(V_VIS);
    localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [9:0] GX_FIRST = 10'(GRID_X0);
    localparam logic [9:0] GX_END   = 10'(GRID_X0 + 10 * CELL);
    localparam logic [9:0] GX_LAST  = 10'(GRID_X0 + 10 * CELL - 1);
    localparam logic [9:0] GY_FIRST = 10'(GRID_Y0);
    localparam logic [9:0] GY_END   = 10'(GRID_Y0 + 10 * CELL);
    localparam logic [9:0] GY_LAST  = 10'(GRID_Y0 + 10 * CELL - 1);
    localparam logic [5:0] OFF_LAST = 6'(CELL - 1);

    typedef enum logic [1:0] {
        PX_BLANK,
        PX_BG,
        PX_LINE,
        PX_CELL
    } px_kind_t;

    // Counters and cell-position tracking
    logic [9:0]   hc, vc, hc_next, vc_next;
    logic [5:0]   xoff, yoff;
    logic [4:0]   col;
    logic [3:0]   row;
    logic [399:0] fb;

    always_comb begin
        hc_next = (hc == HC_LAST) ? 10'd0 : hc + 10'd1;
        vc_next = (vc == VC_LAST) ? 10'd0 : vc + 10'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hc <= 10'd0;
            vc <= 10'd0;
        end else begin
            hc <= hc_next;
            if (hc == HC_LAST) begin
                vc <= vc_next;
            end
        end
    end

    // Column/x-offset restart when hc enters GRID_X0; values outside the grid
    // are never used, so they are allowed to run on freely.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xoff <= 6'd0;
            col  <= 5'd0;
        end else if (hc_next == GX_FIRST) begin
            xoff <= 6'd0;
            col  <= 5'd0;
        end else if (xoff == OFF_LAST) begin
            xoff <= 6'd0;
            col  <= col + 5'd1;
        end else begin
            xoff <= xoff + 6'd1;
        end
    end

    // Row/y-offset advance once per line, restarting when vc enters GRID_Y0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            yoff <= 6'd0;
            row  <= 4'd0;
        end else if (hc == HC_LAST) begin
            if (vc_next == GY_FIRST) begin
                yoff <= 6'd0;
                row  <= 4'd0;
            end else if (yoff == OFF_LAST) begin
                yoff <= 6'd0;
                row  <= row + 4'd1;
            end else begin
                yoff <= yoff + 6'd1;
            end
        end
    end

    // Frame buffer snapshot; vc==V_VIS is never visible so reads cannot collide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fb <= '0;
        end else if (hc == 10'd0 && vc == VC_VIS) begin
            fb <= matriz;
        end
    end

    // Stage 1: classification and buffer read
    logic       vis, in_grid, on_line;
    logic [6:0] idx;
    logic [3:0] cell_val;
    px_kind_t   kind;

    always_comb begin
        vis      = (hc < HC_VIS) && (vc < VC_VIS);
        in_grid  = (hc >= GX_FIRST) && (hc < GX_END) && (vc >= GY_FIRST) && (vc < GY_END);
        on_line  = (xoff == 6'd0) || (yoff == 6'd0) || (hc == GX_LAST) || (vc == GY_LAST);
        idx      = in_grid ? ({3'b000, row} * 7'd10 + {2'b00, col}) : 7'd0;
        cell_val = fb[{idx, 2'b00} +: 4];
        if (!vis) begin
            kind = PX_BLANK;
        end else if (!in_grid) begin
            kind = PX_BG;
        end else if (on_line) begin
            kind = PX_LINE;
        end else begin
            kind = PX_CELL;
        end
    end

    px_kind_t   s1_kind;
    logic [3:0] s1_val;
    logic       s1_hs, s1_vs, s1_fs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_kind <= PX_BLANK;
            s1_val  <= 4'd0;
            s1_hs   <= 1'b1;
            s1_vs   <= 1'b1;
            s1_fs   <= 1'b0;
        end else begin
            s1_kind <= kind;
            s1_val  <= cell_val;
            s1_hs   <= !((hc >= HS_FIRST) && (hc <= HS_LAST));
            s1_vs   <= !((vc >= VS_FIRST) && (vc <= VS_LAST));
            s1_fs   <= (hc == 10'd0) && (vc == 10'd0);
        end
    end

    // Stage 2: palette lookup and registered outputs
    function automatic logic [23:0] palette(input logic [3:0] v);
        logic [7:0] grey;
        grey = {v[2:0], 5'h1F};
        if (v[3]) begin
            return {grey, grey, grey};
        end
        case (v[2:0])
            3'd0:    return 24'h000000;
            3'd1:    return 24'hFF0000;
            3'd2:    return 24'h00FF00;
            3'd3:    return 24'h0000FF;
            3'd4:    return 24'hFFFF00;
            3'd5:    return 24'h00FFFF;
            3'd6:    return 24'hFF00FF;
            default: return 24'hFFFFFF;
        endcase
    endfunction

    logic [23:0] px_rgb;

    always_comb begin
        px_rgb = 24'h000000;
        case (s1_kind)
            PX_BG:   px_rgb = 24'h101010;
            PX_LINE: px_rgb = 24'h404040;
            PX_CELL: px_rgb = palette(s1_val);
            default: px_rgb = 24'h000000;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank_n     <= 1'b0;
            r           <= 8'd0;
            g           <= 8'd0;
            b           <= 8'd0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= s1_hs;
            vsync       <= s1_vs;
            blank_n     <= (s1_kind != PX_BLANK);
            r           <= px_rgb[23:16];
            g           <= px_rgb[15:8];
            b           <= px_rgb[7:0];
            frame_start <= s1_fs;
        end
    end

endmodule

// File: tb/tb_matriz_vga_renderer.sv
// tb/tb_matriz_vga_renderer.sv - randomized self-checking bench for matriz_vga_renderer on a reduced raster

module tb_matriz_vga_renderer;

    localparam int HV = 64, HF = 4, HS = 8, HB = 4;
    localparam int VV = 60, VF = 2, VS = 2, VB = 3;
    localparam int GX = 10, GY = 8, CL = 4;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam logic [27:0] RST_VEC = {1'b1, 1'b1, 1'b0, 1'b0, 24'h000000};

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [9:0][9:0][3:0] matriz = '0;
    logic                 hsync, vsync, blank_n, frame_start;
    logic [7:0]           r, g, b;

    always #5 clk = ~clk;

    matriz_vga_renderer #(
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .GRID_X0(GX), .GRID_Y0(GY), .CELL(CL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .matriz(matriz),
        .hsync(hsync),
        .vsync(vsync),
        .blank_n(blank_n),
        .r(r),
        .g(g),
        .b(b),
        .frame_start(frame_start)
    );

    logic [23:0] pal [16] = '{
        24'h000000, 24'hFF0000, 24'h00FF00, 24'h0000FF,
        24'hFFFF00, 24'h00FFFF, 24'hFF00FF, 24'hFFFFFF,
        24'h1F1F1F, 24'h3F3F3F, 24'h5F5F5F, 24'h7F7F7F,
        24'h9F9F9F, 24'hBFBFBF, 24'hDFDFDF, 24'hFFFFFF
    };

    int nvec = 0;
    int nbad = 0;

    int                   mh, mv;
    logic [9:0][9:0][3:0] fbref;
    logic [27:0]          e1, e2;
    int                   e1x, e1y, e2x, e2y;

    task automatic check(input string tag, input logic [27:0] got, input logic [27:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            if (nbad <= 20) begin
                $display("FAIL %s got={hs,vs,bl,fs}=%b rgb=%h exp={hs,vs,bl,fs}=%b rgb=%h",
                         tag, got[27:24], got[23:0], exp[27:24], exp[23:0]);
            end
        end
    endtask

    function automatic logic [27:0] ref_px(input int x, input int y, input logic [9:0][9:0][3:0] fbuf);
        logic        hs, vs, bl, fs;
        logic [23:0] c;
        int          dx, dy;
        hs = !(x >= HV + HF && x < HV + HF + HS);
        vs = !(y >= VV + VF && y < VV + VF + VS);
        fs = (x == 0) && (y == 0);
        bl = (x < HV) && (y < VV);
        c  = 24'h000000;
        if (bl) begin
            if (x < GX || x >= GX + 10 * CL || y < GY || y >= GY + 10 * CL) begin
                c = 24'h101010;
            end else begin
                dx = x - GX;
                dy = y - GY;
                if (dx % CL == 0 || dy % CL == 0 || dx == 10 * CL - 1 || dy == 10 * CL - 1)
                    c = 24'h404040;
                else
                    c = pal[fbuf[dy / CL][dx / CL]];
            end
        end
        return {hs, vs, bl, fs, c};
    endfunction

    // One clock: update the model at the edge, compare at the falling edge,
    // then optionally poke a random cell.
    task automatic tick(input bit pokes);
        @(posedge clk);
        if (!rst) begin
            mh = 0; mv = 0; fbref = '0;
            e1 = RST_VEC; e2 = RST_VEC;
            e1x = -1; e1y = -1; e2x = -1; e2y = -1;
        end else begin
            e2 = e1; e2x = e1x; e2y = e1y;
            e1 = ref_px(mh, mv, fbref); e1x = mh; e1y = mv;
            if (mh == 0 && mv == VV) fbref = matriz;
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end
        end
        @(negedge clk);
        if (!rst)
            check("reset", {hsync, vsync, blank_n, frame_start, r, g, b}, RST_VEC);
        else
            check($sformatf("px(%0d,%0d)", e2x, e2y),
                  {hsync, vsync, blank_n, frame_start, r, g, b}, e2);
        if (pokes && $urandom_range(0, 31) == 0)
            matriz[$urandom_range(0, 9)][$urandom_range(0, 9)] = 4'($urandom);
    endtask

    task automatic run(input int n, input bit pokes);
        for (int i = 0; i < n; i++) tick(pokes);
    endtask

    initial begin
        mh = 0; mv = 0; fbref = '0;
        e1 = RST_VEC; e2 = RST_VEC;
        e1x = -1; e1y = -1; e2x = -1; e2y = -1;

        run(5, 1'b0);
        rst = 1'b1;
        run(HT * 10 + 37, 1'b0);
        rst = 1'b0;
        run(5, 1'b0);
        rst = 1'b1;

        matriz[0][0] = 4'd1;
        matriz[9][9] = 4'd15;
        matriz[0][1] = 4'd9;
        run(2 * FRAME, 1'b0);

        matriz[0][0] = 4'd2;
        run(FRAME, 1'b0);
        run(HT * 30, 1'b0);
        matriz[0][0] = 4'd3;
        run(FRAME, 1'b0);

        for (int k = 0; k < 100; k++) matriz[k / 10][k % 10] = 4'($urandom);
        run(4 * FRAME, 1'b1);

        for (int k = 0; k < 100; k++) matriz[k / 10][k % 10] = 4'($urandom_range(1, 15));
        run(FRAME - (HT * 5), 1'b0);
        run(HT * 40 + 17, 1'b0);
        rst = 1'b0;
        run(5, 1'b0);
        rst = 1'b1;
        run(FRAME + HT * 3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
